rfm_cnt_ctrl: RTL and testbench
===============================

Name: rfm_cnt_ctrl

Overview:
- Upstream controller for the row-activation counter CAM (cnt_cam) in the RFM tracker.
- Accepts ACT row addresses and keeps a row-tag table mapping rows to CAM entries. Drives the CAM's read, write, search, reset and max ports to increment per-row counts.
- On an RFM request, runs the CAM's 4-cycle max sweep, locates the hottest entry, reports its row and clears it.

Parameters:
WORD_SIZE, 16, counter width (matches CAM)
ENTRY_WIDTH, 7, CAM entry index width
ROW_NUM, 68, number of CAM entries / tag slots
ROW_ADDR_WIDTH, 17, DRAM row address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
act_valid  in  1  ACT command present
act_row  in  ROW_ADDR_WIDTH  activated row
act_ready  out  1  ACT accepted when valid&ready
rfm_req  in  1  RFM mitigation request (level, sampled in IDLE)
rfm_busy  out  1  RFM sequence in progress
rfm_done  out  1  one-cycle pulse, RFM result valid
rfm_hit  out  1  with rfm_done: a non-zero count was found
rfm_row  out  ROW_ADDR_WIDTH  aggressor row (valid with rfm_done&rfm_hit)
rfm_cnt  out  WORD_SIZE  its count
win_clear  in  1  refresh-window clear request
spill_cnt  out  WORD_SIZE  ACTs dropped because the table was full (saturating)
cam_data_in  out  WORD_SIZE
cam_addr_in  out  ENTRY_WIDTH
cam_read_en / cam_write_en / cam_search_en / cam_reset / cam_max_en  out  1 each
cam_data_out  in  WORD_SIZE
cam_addr_out  in  ENTRY_WIDTH
cam_match  in  1
cam_max  in  WORD_SIZE

Behaviour:
- FSM states: INIT, IDLE, LOOKUP, INCR, MAX0..MAX3, MSRCH, MCLR, CLEAR. CAM controls decode from state plus registered operands.
- Reset:
  - rst forces INIT, all tag valids 0, spill_cnt 0, and all outputs 0.
  - INIT asserts cam_reset=1 for one cycle, then goes to IDLE.
  - act_ready is first 1 on the second clk edge after rst release.
  - Reset mid-sequence aborts the sequence; no rfm_done is issued.
- IDLE priority: win_clear > rfm_req > ACT. act_ready = (state==IDLE) & ~win_clear & ~rfm_req.
- CLEAR: cam_reset=1 for one cycle, all tags invalidated, spill_cnt←0, then IDLE.
- ACT path:
  - On handshake, register act_row and go to LOOKUP.
  - LOOKUP compares against all valid tags in parallel (at most one hit by construction).
  - Hit: cam_read_en=1, cam_addr_in=entry; sample cam_data_out at end of cycle.
  - Miss with a free slot: allocate the lowest-index invalid slot, set its tag/valid, operand=0.
  - Miss with the table full: spill_cnt++ (saturate at all-ones), no CAM write, return to IDLE.
  - INCR: cam_write_en=1, cam_addr_in=entry, cam_data_in=operand+1, saturating at 2^WORD_SIZE-1.
  - Next ACT can be accepted 3 cycles after the previous accept.
- RFM path:
  - On accept, rfm_busy=1.
  - MAX0..MAX3: cam_max_en=1 for exactly 4 consecutive cycles. cam_max is valid in MSRCH.
  - MSRCH with cam_max==0: rfm_done with rfm_hit=0, go to IDLE.
  - MSRCH otherwise: cam_search_en=1, cam_data_in=cam_max; latch cam_addr_out and cam_max.
  - MCLR: cam_write_en=1 writing 0 to the latched entry; its tag is invalidated.
  - Registered rfm_done/rfm_hit=1, with rfm_row=tag[entry] and rfm_cnt=max, in the cycle after MCLR.
  - rfm_busy drops in the same cycle as rfm_done. Accept-to-done latency is 7 cycles.
  - cam_match=0 in MSRCH (inconsistency): rfm_done with rfm_hit=0, no write.
- rfm_row and rfm_cnt hold their values until the next rfm_done.
- Inputs other than rst are ignored outside IDLE. win_clear or rfm_req held high is serviced after the current sequence completes.

Test Plan:
- Release rst -> cam_reset pulses once; act_ready=1 on the 2nd edge; all outputs 0 before that.
- Five ACTs to row 0x1A2B, then RFM -> cam_max_en high for exactly 4 cycles, rfm_done 7 cycles after accept, rfm_hit=1, rfm_row=0x1A2B, rfm_cnt=5. A second RFM returns rfm_hit=0.
- ACT rows A×3, B×7, C×2, then RFM -> rfm_row=B, rfm_cnt=7. A following RFM -> rfm_row=A, rfm_cnt=3.
- Fill 68 distinct rows, then ACT a 69th new row -> spill_cnt=1, no cam_write_en. Then win_clear -> cam_reset pulse, spill_cnt=0, and the next ACT allocates entry 0.
- Preload an entry at 0xFFFF (saturation) and ACT its row -> write data stays 0xFFFF.
- Assert rst during MAX2 -> rfm_busy=0 immediately, no rfm_done, INIT sequence re-runs. Assert win_clear and rfm_req together in IDLE -> CLEAR runs first, then RFM.

Source files
------------

// File: rtl/rfm_cnt_ctrl.sv
// rfm_cnt_ctrl: front-end controller for the row-activation counter CAM.
// Maps ACT rows to CAM entries through a tag table and bumps their counts.
// On an RFM request it sweeps the CAM for the hottest entry, reports it and clears it.
module rfm_cnt_ctrl #(
  parameter int unsigned WORD_SIZE      = 16,
  parameter int unsigned ENTRY_WIDTH    = 7,
  parameter int unsigned ROW_NUM        = 68,
  parameter int unsigned ROW_ADDR_WIDTH = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  // ACT command interface
  input  logic                      act_valid,
  input  logic [ROW_ADDR_WIDTH-1:0] act_row,
  output logic                      act_ready,
  // RFM interface
  input  logic                      rfm_req,
  output logic                      rfm_busy,
  output logic                      rfm_done,
  output logic                      rfm_hit,
  output logic [ROW_ADDR_WIDTH-1:0] rfm_row,
  output logic [WORD_SIZE-1:0]      rfm_cnt,
  // Window management
  input  logic                      win_clear,
  output logic [WORD_SIZE-1:0]      spill_cnt,
  // CAM interface
  output logic [WORD_SIZE-1:0]      cam_data_in,
  output logic [ENTRY_WIDTH-1:0]    cam_addr_in,
  output logic                      cam_read_en,
  output logic                      cam_write_en,
  output logic                      cam_search_en,
  output logic                      cam_reset,
  output logic                      cam_max_en,
  input  logic [WORD_SIZE-1:0]      cam_data_out,
  input  logic [ENTRY_WIDTH-1:0]    cam_addr_out,
  input  logic                      cam_match,
  input  logic [WORD_SIZE-1:0]      cam_max
);

  typedef enum logic [3:0] {
    StInit,
    StIdle,
    StLookup,
    StIncr,
    StMax0,
    StMax1,
    StMax2,
    StMax3,
    StMsrch,
    StMclr,
    StClear
  } state_e;

  localparam logic [WORD_SIZE-1:0] CntMax = {WORD_SIZE{1'b1}};

  state_e state_q, state_d;

  // INIT waits one cycle after reset release so cam_reset stays low while rst is held.
  logic                      init_arm_q;

  logic [ROW_ADDR_WIDTH-1:0] tag_q [ROW_NUM];
  logic [ROW_NUM-1:0]        valid_q;
  logic [ROW_ADDR_WIDTH-1:0] row_q;
  logic [ENTRY_WIDTH-1:0]    entry_q;
  logic [WORD_SIZE-1:0]      operand_q;
  logic [WORD_SIZE-1:0]      max_q;
  logic [WORD_SIZE-1:0]      spill_q;
  logic                      rfm_done_q;
  logic                      rfm_hit_q;
  logic [ROW_ADDR_WIDTH-1:0] rfm_row_q;
  logic [WORD_SIZE-1:0]      rfm_cnt_q;

  logic                      hit;
  logic [ENTRY_WIDTH-1:0]    hit_idx;
  logic                      free;
  logic [ENTRY_WIDTH-1:0]    free_idx;
  logic [WORD_SIZE-1:0]      incr_val;

  // Parallel tag match and lowest-free-slot search; descending loop lets low indices win.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = ROW_NUM - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == row_q)) begin
        hit     = 1'b1;
        hit_idx = ENTRY_WIDTH'(i);
      end
      if (!valid_q[i]) begin
        free     = 1'b1;
        free_idx = ENTRY_WIDTH'(i);
      end
    end
  end

  // Saturating increment of the fetched count.
  always_comb begin
    incr_val = (operand_q == CntMax) ? operand_q : operand_q + 1'b1;
  end

  // Next-state and CAM control decode.
  always_comb begin
    state_d       = state_q;
    act_ready     = 1'b0;
    cam_data_in   = '0;
    cam_addr_in   = '0;
    cam_read_en   = 1'b0;
    cam_write_en  = 1'b0;
    cam_search_en = 1'b0;
    cam_reset     = 1'b0;
    cam_max_en    = 1'b0;
    unique case (state_q)
      StInit: begin
        if (init_arm_q) begin
          cam_reset = 1'b1;
          state_d   = StIdle;
        end
      end
      StIdle: begin
        if (win_clear) begin
          state_d = StClear;
        end else if (rfm_req) begin
          state_d = StMax0;
        end else begin
          act_ready = 1'b1;
          if (act_valid) state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          cam_read_en = 1'b1;
          cam_addr_in = hit_idx;
          state_d     = StIncr;
        end else if (free) begin
          state_d = StIncr;
        end else begin
          state_d = StIdle;
        end
      end
      StIncr: begin
        cam_write_en = 1'b1;
        cam_addr_in  = entry_q;
        cam_data_in  = incr_val;
        state_d      = StIdle;
      end
      StMax0: begin
        cam_max_en = 1'b1;
        state_d    = StMax1;
      end
      StMax1: begin
        cam_max_en = 1'b1;
        state_d    = StMax2;
      end
      StMax2: begin
        cam_max_en = 1'b1;
        state_d    = StMax3;
      end
      StMax3: begin
        cam_max_en = 1'b1;
        state_d    = StMsrch;
      end
      StMsrch: begin
        if (cam_max == '0) begin
          state_d = StIdle;
        end else begin
          cam_search_en = 1'b1;
          cam_data_in   = cam_max;
          // No match means CAM and max disagree; report a miss rather than clear a wrong entry.
          state_d       = cam_match ? StMclr : StIdle;
        end
      end
      StMclr: begin
        cam_write_en = 1'b1;
        cam_addr_in  = entry_q;
        cam_data_in  = '0;
        state_d      = StIdle;
      end
      StClear: begin
        cam_reset = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StInit;
      init_arm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_arm_q <= (state_q == StInit);
    end
  end

  // Operand, tag-valid, spill and RFM result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      row_q      <= '0;
      entry_q    <= '0;
      operand_q  <= '0;
      max_q      <= '0;
      spill_q    <= '0;
      rfm_done_q <= 1'b0;
      rfm_hit_q  <= 1'b0;
      rfm_row_q  <= '0;
      rfm_cnt_q  <= '0;
    end else begin
      rfm_done_q <= 1'b0;
      rfm_hit_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (act_ready && act_valid) row_q <= act_row;
        end
        StLookup: begin
          if (hit) begin
            entry_q   <= hit_idx;
            operand_q <= cam_data_out;
          end else if (free) begin
            entry_q           <= free_idx;
            operand_q         <= '0;
            valid_q[free_idx] <= 1'b1;
          end else if (spill_q != CntMax) begin
            spill_q <= spill_q + 1'b1;
          end
        end
        StMsrch: begin
          if ((cam_max != '0) && cam_match) begin
            entry_q <= cam_addr_out;
            max_q   <= cam_max;
          end else begin
            rfm_done_q <= 1'b1;
          end
        end
        StMclr: begin
          valid_q[entry_q] <= 1'b0;
          rfm_done_q       <= 1'b1;
          rfm_hit_q        <= 1'b1;
          rfm_row_q        <= tag_q[entry_q];
          rfm_cnt_q        <= max_q;
        end
        StClear: begin
          valid_q <= '0;
          spill_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Tag storage; contents are qualified by valid_q so no reset is needed.
  always_ff @(posedge clk) begin
    if ((state_q == StLookup) && !hit && free) tag_q[free_idx] <= row_q;
  end

  assign rfm_busy  = (state_q == StMax0) || (state_q == StMax1) || (state_q == StMax2) ||
                     (state_q == StMax3) || (state_q == StMsrch) || (state_q == StMclr);
  assign rfm_done  = rfm_done_q;
  assign rfm_hit   = rfm_hit_q;
  assign rfm_row   = rfm_row_q;
  assign rfm_cnt   = rfm_cnt_q;
  assign spill_cnt = spill_q;

endmodule

// File: tb/tb_rfm_cnt_ctrl.sv
// Directed bench for rfm_cnt_ctrl with a behavioural counter-CAM model.
module tb_rfm_cnt_ctrl;
  localparam int WS = 16;
  localparam int EW = 7;
  localparam int RN = 68;
  localparam int RW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          act_valid = 1'b0;
  logic [RW-1:0] act_row = '0;
  logic          act_ready;
  logic          rfm_req = 1'b0;
  logic          rfm_busy, rfm_done, rfm_hit;
  logic [RW-1:0] rfm_row;
  logic [WS-1:0] rfm_cnt;
  logic          win_clear = 1'b0;
  logic [WS-1:0] spill_cnt;
  logic [WS-1:0] cam_data_in;
  logic [EW-1:0] cam_addr_in;
  logic          cam_read_en, cam_write_en, cam_search_en, cam_reset, cam_max_en;
  logic [WS-1:0] cam_data_out;
  logic [EW-1:0] cam_addr_out;
  logic          cam_match;
  logic [WS-1:0] cam_max;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rfm_cnt_ctrl #(
    .WORD_SIZE(WS), .ENTRY_WIDTH(EW), .ROW_NUM(RN), .ROW_ADDR_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst),
    .act_valid(act_valid), .act_row(act_row), .act_ready(act_ready),
    .rfm_req(rfm_req), .rfm_busy(rfm_busy), .rfm_done(rfm_done), .rfm_hit(rfm_hit),
    .rfm_row(rfm_row), .rfm_cnt(rfm_cnt),
    .win_clear(win_clear), .spill_cnt(spill_cnt),
    .cam_data_in(cam_data_in), .cam_addr_in(cam_addr_in),
    .cam_read_en(cam_read_en), .cam_write_en(cam_write_en), .cam_search_en(cam_search_en),
    .cam_reset(cam_reset), .cam_max_en(cam_max_en),
    .cam_data_out(cam_data_out), .cam_addr_out(cam_addr_out),
    .cam_match(cam_match), .cam_max(cam_max)
  );

  // CAM model: async read/search, max valid after four consecutive max_en cycles.
  logic [WS-1:0] mem [RN];
  logic          poke_en = 1'b0;
  logic [EW-1:0] poke_addr = '0;
  logic [WS-1:0] poke_data = '0;
  int            max_run = 0;
  logic [WS-1:0] maxval;

  always @(posedge clk) begin
    if (cam_reset) begin
      for (int i = 0; i < RN; i++) mem[i] <= '0;
    end else if (cam_write_en) begin
      mem[cam_addr_in] <= cam_data_in;
    end
    if (poke_en) mem[poke_addr] <= poke_data;
    max_run <= cam_max_en ? max_run + 1 : 0;
  end

  always_comb begin
    maxval = '0;
    for (int i = 0; i < RN; i++) if (mem[i] > maxval) maxval = mem[i];
    cam_max      = (max_run == 4) ? maxval : '0;
    cam_data_out = cam_read_en ? mem[cam_addr_in] : '0;
    cam_match    = 1'b0;
    cam_addr_out = '0;
    if (cam_search_en) begin
      for (int i = RN - 1; i >= 0; i--) begin
        if (mem[i] == cam_data_in) begin
          cam_match    = 1'b1;
          cam_addr_out = EW'(i);
        end
      end
    end
  end

  // Event monitor sampled at the active edge.
  int            n_wr = 0, n_maxen = 0, n_crst = 0, n_done = 0;
  logic [WS-1:0] wr_data = '0;
  logic [EW-1:0] wr_addr = '0;

  always @(posedge clk) begin
    if (cam_write_en) begin
      n_wr    <= n_wr + 1;
      wr_data <= cam_data_in;
      wr_addr <= cam_addr_in;
    end
    if (cam_max_en) n_maxen <= n_maxen + 1;
    if (cam_reset)  n_crst  <= n_crst + 1;
    if (rfm_done)   n_done  <= n_done + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int bound);
    int k = 0;
    #1;
    while (!act_ready && k < bound) begin
      cyc();
      k++;
    end
    check_val("ready_wait", 32'(act_ready), 32'd1);
  endtask

  task automatic do_act(input logic [RW-1:0] row);
    act_row   = row;
    act_valid = 1'b1;
    wait_ready(20);
    cyc();
    act_valid = 1'b0;
  endtask

  // Issues an RFM and returns the number of edges from accept to rfm_done.
  task automatic do_rfm(output int lat);
    wait_ready(20);
    rfm_req = 1'b1;
    cyc();
    rfm_req = 1'b0;
    lat = 1;
    #1;
    while (!rfm_done && lat < 20) begin
      cyc();
      lat++;
    end
    check_val("done_seen", 32'(rfm_done), 32'd1);
  endtask

  int lat, snap, snap2;

  initial begin
    // Reset behaviour
    cyc();
    cyc();
    check_val("rst_outs", {cam_reset, act_ready, rfm_busy, rfm_done, rfm_hit, cam_read_en,
                           cam_write_en, cam_search_en, cam_max_en}, 32'd0);
    check_val("rst_spill", 32'(spill_cnt), 32'd0);
    snap = n_crst;
    rst  = 1'b0;
    #1;
    check_val("pre_arm_camrst", 32'(cam_reset), 32'd0);
    cyc();
    check_val("init_camrst", 32'(cam_reset), 32'd1);
    check_val("init_ready", 32'(act_ready), 32'd0);
    cyc();
    check_val("idle_ready", 32'(act_ready), 32'd1);
    check_val("camrst_once", 32'(n_crst - snap), 32'd1);

    // Single hot row
    do_act(17'h1A2B);
    check_val("lookup_ready", 32'(act_ready), 32'd0);
    cyc();
    check_val("incr_we", {cam_write_en, 9'(cam_addr_in), cam_data_in}, {1'b1, 9'd0, 16'd1});
    cyc();
    check_val("act_spacing", 32'(act_ready), 32'd1);
    for (int i = 0; i < 4; i++) do_act(17'h1A2B);
    wait_ready(20);
    check_val("five_acts", 32'(wr_data), 32'd5);
    snap = n_maxen;
    do_rfm(lat);
    check_val("rfm_latency", 32'(lat), 32'd7);
    check_val("max_en_cnt", 32'(n_maxen - snap), 32'd4);
    check_val("rfm1_hit", 32'(rfm_hit), 32'd1);
    check_val("rfm1_row", 32'(rfm_row), 32'h1A2B);
    check_val("rfm1_cnt", 32'(rfm_cnt), 32'd5);
    check_val("done_busy", 32'(rfm_busy), 32'd0);
    cyc();
    check_val("done_pulse", 32'(rfm_done), 32'd0);
    check_val("row_hold", 32'(rfm_row), 32'h1A2B);
    check_val("mclr_write", {9'(wr_addr), wr_data}, 32'd0);
    do_rfm(lat);
    check_val("rfm2_hit", 32'(rfm_hit), 32'd0);

    // Ranking among several rows
    for (int i = 0; i < 3; i++) do_act(17'h00011);
    for (int i = 0; i < 7; i++) do_act(17'h1FFFF);
    for (int i = 0; i < 2; i++) do_act(17'h00100);
    do_rfm(lat);
    check_val("rank1", {rfm_hit, 15'(rfm_row), rfm_cnt}, {1'b1, 15'h7FFF, 16'd7});
    check_val("rank1_row", 32'(rfm_row), 32'h1FFFF);
    do_rfm(lat);
    check_val("rank2_row", 32'(rfm_row), 32'h00011);
    check_val("rank2_cnt", 32'(rfm_cnt), 32'd3);

    // Table full / spill, then window clear
    wait_ready(20);
    win_clear = 1'b1;
    cyc();
    win_clear = 1'b0;
    for (int i = 0; i < RN; i++) do_act(17'h00200 + 17'(i));
    wait_ready(20);
    check_val("fill_last", {9'(wr_addr), wr_data}, {9'd67, 16'd1});
    snap = n_wr;
    do_act(17'h1FF00);
    wait_ready(20);
    check_val("spill_cnt", 32'(spill_cnt), 32'd1);
    check_val("spill_nowrite", 32'(n_wr - snap), 32'd0);
    snap = n_crst;
    win_clear = 1'b1;
    #1;
    check_val("clear_prio", 32'(act_ready), 32'd0);
    cyc();
    win_clear = 1'b0;
    check_val("clear_camrst", 32'(cam_reset), 32'd1);
    cyc();
    check_val("clear_spill", 32'(spill_cnt), 32'd0);
    check_val("clear_once", 32'(n_crst - snap), 32'd1);
    do_act(17'h00ABC);
    wait_ready(20);
    check_val("realloc0", {9'(wr_addr), wr_data}, {9'd0, 16'd1});

    // Counter saturation
    poke_addr = '0;
    poke_data = 16'hFFFF;
    poke_en   = 1'b1;
    cyc();
    poke_en = 1'b0;
    do_act(17'h00ABC);
    wait_ready(20);
    check_val("saturate", {9'(wr_addr), wr_data}, {9'd0, 16'hFFFF});

    // Reset during the max sweep
    wait_ready(20);
    rfm_req = 1'b1;
    cyc();
    rfm_req = 1'b0;
    cyc();
    cyc();
    check_val("in_max2", {rfm_busy, cam_max_en}, 32'd3);
    snap  = n_done;
    snap2 = n_crst;
    rst   = 1'b1;
    #1;
    check_val("abort_busy", {rfm_busy, cam_max_en, cam_reset}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    check_val("reinit_camrst", 32'(cam_reset), 32'd1);
    cyc();
    check_val("reinit_ready", 32'(act_ready), 32'd1);
    check_val("abort_nodone", 32'(n_done - snap), 32'd0);
    check_val("reinit_camrst_cnt", 32'(n_crst - snap2), 32'd1);

    // win_clear and rfm_req together: clear first, then RFM finds nothing
    do_act(17'h00777);
    do_act(17'h00777);
    wait_ready(20);
    win_clear = 1'b1;
    rfm_req   = 1'b1;
    cyc();
    win_clear = 1'b0;
    check_val("prio_clear", {cam_reset, rfm_busy}, 32'd2);
    cyc();
    check_val("prio_idle", 32'(rfm_busy), 32'd0);
    cyc();
    rfm_req = 1'b0;
    check_val("prio_rfm", {rfm_busy, cam_max_en}, 32'd3);
    lat = 0;
    while (!rfm_done && lat < 20) begin
      cyc();
      lat++;
    end
    check_val("prio_done", {rfm_done, rfm_hit}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
